control_sequencer: RTL and testbench



---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/ctrl_timeout_counter.sv | 34 +++
 rtl/control_sequencer.sv | 121 ++++++++++++
 tb/tb_control_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and opcode helpers for the multi-cycle control sequencer.
// Opcode map derives from the ALU op width.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    WAIT_ALU,
    WRITEBACK
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;
  localparam logic [1:0] ALU_DIV = 2'd3;

  function automatic int op_read(input int alu_op_w);
    return 1 << alu_op_w;
  endfunction

  function automatic int op_write(input int alu_op_w);
    return (1 << alu_op_w) + 1;
  endfunction

  function automatic logic is_arith(input int opc,
                                    input int alu_op_w);
    return opc < (1 << alu_op_w);
  endfunction

endpackage

// File: rtl/ctrl_timeout_counter.sv
// Wait-cycle counter for the ALU completion watchdog.
// expire_o flags the last permitted wait cycle.
module ctrl_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: decode, ALU launch, wait, writeback.
// All outputs come from registered state and the latched opcode.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W       = 3,
  parameter int ALU_OP_W       = 2,
  parameter logic [2**ALU_OP_W-1:0] MULTICYCLE_MASK = 4'b1100,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  output logic                reg_read,
  output logic                reg_write,
  output logic                switch_input,
  output logic                busy,
  output logic                error
);

  localparam logic [OPCODE_W-1:0] OP_RD =
    OPCODE_W'(op_read(ALU_OP_W));
  localparam logic [OPCODE_W-1:0] OP_WR =
    OPCODE_W'(op_write(ALU_OP_W));

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q;
  logic [ALU_OP_W-1:0] alu_op_q;
  logic                sw_q;
  logic                err_q;

  logic accept;
  logic arith_q;
  logic cnt_clr;
  logic cnt_en;
  logic expire;
  logic set_err;

  assign accept  = (state_q == IDLE) && instr_valid;
  assign arith_q = is_arith(int'(opc_q), ALU_OP_W);

  ctrl_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clr),
    .enable_i(cnt_en),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      IDLE:
        if (instr_valid) state_d = DECODE;
      DECODE:
        state_d = arith_q ? EXEC : IDLE;
      EXEC: begin
        cnt_clr = 1'b1;
        state_d = MULTICYCLE_MASK[alu_op_q] ? WAIT_ALU
                                            : WRITEBACK;
      end
      WAIT_ALU: begin
        cnt_en = 1'b1;
        // done in the expiry cycle still completes normally
        if (alu_done) begin
          state_d = WRITEBACK;
        end else if (expire) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      WRITEBACK:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // alu_op and switch_input are resolved at acceptance so that
  // they are already valid in the DECODE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opc_q    <= '0;
      alu_op_q <= ALU_OP_W'(ALU_ADD);
      sw_q     <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opc_q <= opcode;
        sw_q  <= (opcode > OP_WR);
        if (is_arith(int'(opcode), ALU_OP_W))
          alu_op_q <= opcode[ALU_OP_W-1:0];
      end
      if (set_err)
        err_q <= 1'b1;
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign alu_start    = (state_q == EXEC);
  assign reg_read     = (state_q == DECODE) && (opc_q == OP_RD);
  assign reg_write    = (state_q == WRITEBACK) ||
                        ((state_q == DECODE) && (opc_q == OP_WR));
  assign alu_op       = alu_op_q;
  assign switch_input = sw_q;
  assign error        = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a per-cycle
// timeline model and a few literal latency pins.
module tb_control_sequencer;

  localparam int         T    = 16;
  localparam logic [3:0] MASK = 4'b1100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [2:0] opcode;
  logic       alu_done;
  logic       instr_ready;
  logic [1:0] alu_op;
  logic       alu_start;
  logic       reg_read;
  logic       reg_write;
  logic       switch_input;
  logic       busy;
  logic       error;

  control_sequencer #(
    .OPCODE_W       (3),
    .ALU_OP_W       (2),
    .MULTICYCLE_MASK(MASK),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .reg_read    (reg_read),
    .reg_write   (reg_write),
    .switch_input(switch_input),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       bsy;
    logic       st;
    logic       rd;
    logic       wr;
    logic       sw;
    logic [1:0] op;
    logic       er;
  } rec_t;

  rec_t expq[$];
  int   errors = 0;
  int   checks = 0;

  logic [1:0] m_op;
  logic       m_sw;
  logic       m_err;

  int cyc_no = 0;
  int hs_cyc = 0;
  int st_cyc = 0;
  int wr_cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int st_cnt = 0;
  int bsy_cnt = 0;

  always @(posedge clk) cyc_no++;

  always @(negedge clk) begin
    if (alu_start) begin st_cnt++; st_cyc = cyc_no; end
    if (reg_write) begin wr_cnt++; wr_cyc = cyc_no; end
    if (reg_read) rd_cnt++;
    if (busy) bsy_cnt++;
  end

  always @(negedge clk) begin
    rec_t a;
    rec_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      a = {instr_ready, busy, alu_start, reg_read,
           reg_write, switch_input, alu_op, error};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle %0d rdy,bsy,st,rd,wr,sw,op,err got=%b required=%b",
                 cyc_no, a, e);
      end
    end
  end

  task automatic check(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", n, got, exp);
    end
  endtask

  function automatic rec_t idle_rec();
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_sw, m_op, m_err};
  endfunction

  function automatic rec_t busy_rec(input logic s, input logic r,
                                    input logic w);
    return {1'b0, 1'b1, s, r, w, m_sw, m_op, m_err};
  endfunction

  function automatic rec_t rst_rec();
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
  endfunction

  task automatic cyc(input logic v, input logic [2:0] o,
                     input logic d, input rec_t e);
    @(posedge clk);
    #1;
    instr_valid = v;
    opcode      = o;
    alu_done    = d;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 1'b0, idle_rec());
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      alu_done    = 1'b0;
      m_op  = 2'b00;
      m_sw  = 1'b1;
      m_err = 1'b0;
      expq.push_back(rst_rec());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expq.push_back(idle_rec());
  endtask

  // d: cycles from alu_start to alu_done (d > T never raises done);
  // for single-cycle ops a nonzero d raises a stray done.
  task automatic instr(input logic [2:0] o, input int d,
                       input logic nv, input logic [2:0] no);
    bit ar;
    int w;
    ar = (o < 3'd4);
    cyc(1'b1, o, 1'b0, idle_rec());
    hs_cyc = cyc_no;
    if (ar) m_op = o[1:0];
    m_sw = (o > 3'd5);
    cyc(nv, no, 1'b0, busy_rec(1'b0, o == 3'd4, o == 3'd5));
    if (ar) begin
      if (MASK[o[1:0]]) begin
        cyc(nv, no, 1'b0, busy_rec(1'b1, 1'b0, 1'b0));
        w = (d <= T) ? d : T;
        for (int i = 1; i <= w; i++)
          cyc(nv, no, i == d, busy_rec(1'b0, 1'b0, 1'b0));
        if (d > T) m_err = 1'b1;
        else cyc(nv, no, 1'b0, busy_rec(1'b0, 1'b0, 1'b1));
      end else begin
        cyc(nv, no, d != 0, busy_rec(1'b1, 1'b0, 1'b0));
        cyc(nv, no, d != 0, busy_rec(1'b0, 1'b0, 1'b1));
      end
    end
  endtask

  int w0, r0, b0;

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = 3'd0;
    alu_done    = 1'b0;
    m_op  = 2'b00;
    m_sw  = 1'b1;
    m_err = 1'b0;
    reset_cycles(2);
    idle(1);

    // ADD, single cycle, stray done ignored
    w0 = wr_cnt;
    instr(3'd0, 1, 1'b0, 3'd0);
    idle(1);
    check("add_start_lat", st_cyc - hs_cyc, 2);
    check("add_wr_lat", wr_cyc - hs_cyc, 3);
    check("add_wr_once", wr_cnt - w0, 1);
    check("add_ready_c4", int'(instr_ready), 1);
    check("add_aluop", int'(alu_op), 0);

    // MUL, done five cycles after start
    w0 = wr_cnt;
    instr(3'd2, 5, 1'b0, 3'd0);
    idle(1);
    check("mul_done_to_wr", wr_cyc - st_cyc, 6);
    check("mul_wr_once", wr_cnt - w0, 1);
    check("mul_err", int'(error), 0);
    check("mul_aluop", int'(alu_op), 2);

    // MUL, done on the last allowed cycle
    w0 = wr_cnt;
    instr(3'd2, T, 1'b0, 3'd0);
    idle(1);
    check("mul_edge_wr", wr_cnt - w0, 1);
    check("mul_edge_err", int'(error), 0);

    // DIV never completes
    w0 = wr_cnt;
    b0 = bsy_cnt;
    instr(3'd3, 1000, 1'b0, 3'd0);
    idle(2);
    check("div_tmo_err", int'(error), 1);
    check("div_no_wr", wr_cnt - w0, 0);
    check("div_busy_cycles", bsy_cnt - b0, 18);

    // READ then WRITE with valid held
    w0 = wr_cnt;
    r0 = rd_cnt;
    instr(3'd4, 0, 1'b1, 3'd5);
    instr(3'd5, 0, 1'b0, 3'd0);
    idle(1);
    check("rw_rd_once", rd_cnt - r0, 1);
    check("rw_wr_once", wr_cnt - w0, 1);
    check("rw_aluop_hold", int'(alu_op), 3);
    check("rw_sw", int'(switch_input), 0);
    check("rw_err_sticky", int'(error), 1);

    // OTHER then SUB
    w0 = wr_cnt;
    instr(3'd7, 0, 1'b0, 3'd0);
    idle(1);
    check("oth_sw", int'(switch_input), 1);
    check("oth_no_wr", wr_cnt - w0, 0);
    instr(3'd1, 0, 1'b0, 3'd0);
    idle(1);
    check("sub_aluop", int'(alu_op), 1);
    check("sub_sw", int'(switch_input), 0);

    // reset in the middle of WAIT_ALU
    w0 = wr_cnt;
    cyc(1'b1, 3'd2, 1'b0, idle_rec());
    m_op = 2'b10;
    m_sw = 1'b0;
    cyc(1'b0, 3'd0, 1'b0, busy_rec(1'b0, 1'b0, 1'b0));
    cyc(1'b0, 3'd0, 1'b0, busy_rec(1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 3'd0, 1'b0, busy_rec(1'b0, 1'b0, 1'b0));
    reset_cycles(1);
    check("rst_no_wr", wr_cnt - w0, 0);
    check("rst_err_clr", int'(error), 0);
    idle(1);
    instr(3'd0, 0, 1'b0, 3'd0);
    idle(2);
    check("post_rst_add_wr", wr_cnt - w0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
